gpio_mulcore: RTL

Parametrised bus-mapped arithmetic coprocessor for the GPIO emulator bus: two operand registers, an iterative shift-add multiplier with optional multiply-accumulate, popcount of the result, a status/control register with sticky error flags, a completion interrupt pulse and an operation counter exported on gpio_out. It is the successor of the fixed 24-bit single-mode multiplier peripheral. All bus activity is synchronous to clk.

---
 rtl/gpio_mulcore_pkg.sv | 27 ++
 rtl/gpio_mulcore_popcount.sv | 17 +
 rtl/gpio_mulcore.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gpio_mulcore_pkg.sv
// rtl/gpio_mulcore_pkg.sv - shared types, default bus map and status bit layout for gpio_mulcore
package gpio_mulcore_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_COUNT,
    S_FINISH
  } state_e;

  localparam logic [15:0] DEF_ADDR_A1   = 16'h037F;
  localparam logic [15:0] DEF_ADDR_A2   = 16'h0388;
  localparam logic [15:0] DEF_ADDR_RESL = 16'h0390;
  localparam logic [15:0] DEF_ADDR_RESH = 16'h03A8;
  localparam logic [15:0] DEF_ADDR_ONES = 16'h0398;
  localparam logic [15:0] DEF_ADDR_CSR  = 16'h03A0;

  localparam int STAT_VALID = 0;
  localparam int STAT_READY = 1;
  localparam int STAT_ERR   = 2;
  localparam int STAT_CARRY = 3;

  localparam int   CSR_MODE_BIT = 1;
  localparam logic MODE_MUL     = 1'b0;
  localparam logic MODE_MAC     = 1'b1;

endpackage

// File: rtl/gpio_mulcore_popcount.sv
// rtl/gpio_mulcore_popcount.sv - combinational ones counter
module gpio_mulcore_popcount #(
  parameter int IN_W  = 32,
  parameter int OUT_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] ones_o
);

  always_comb begin
    ones_o = '0;
    for (int i = 0; i < IN_W; i++) begin
      ones_o = ones_o + OUT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/gpio_mulcore.sv
// rtl/gpio_mulcore.sv - bus-mapped shift-add multiplier / MAC with popcount, status and irq
// Operands are snapshotted at start so the bus may reload A1/A2 while an operation runs.
module gpio_mulcore
  import gpio_mulcore_pkg::*;
#(
  parameter int          OP_W      = 24,
  parameter int          DATA_W    = 32,
  parameter logic [15:0] ADDR_A1   = DEF_ADDR_A1,
  parameter logic [15:0] ADDR_A2   = DEF_ADDR_A2,
  parameter logic [15:0] ADDR_RESL = DEF_ADDR_RESL,
  parameter logic [15:0] ADDR_RESH = DEF_ADDR_RESH,
  parameter logic [15:0] ADDR_ONES = DEF_ADDR_ONES,
  parameter logic [15:0] ADDR_CSR  = DEF_ADDR_CSR
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [15:0]       saddress,
  input  logic              srd,
  input  logic              swr,
  input  logic [DATA_W-1:0] sdata_in,
  output logic [DATA_W-1:0] sdata_out,
  input  logic [31:0]       gpio_in,
  input  logic              gpio_latch,
  output logic [31:0]       gpio_in_s_insp,
  output logic [31:0]       gpio_out,
  output logic              irq
);

  localparam int ACC_W = 2 * OP_W;
  localparam int CNT_W = $clog2(OP_W);

  state_e              state_q;
  logic [OP_W-1:0]     a1_q, a2_q, wb_q;
  logic [ACC_W-1:0]    wa_q, prod_q, acc_q, acc_d;
  logic [ACC_W:0]      mac_sum;
  logic [CNT_W-1:0]    cnt_q;
  logic                mode_q, carry_pend_q;
  logic                err_q, err_d, carry_q, carry_d;
  logic [31:0]         resl_q, resh_q, insp_q;
  logic [5:0]          ones_q, ones_w;
  logic [15:0]         op_count_q;
  logic                srd_prev_q, swr_prev_q, latch_prev_q, irq_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [63:0]         acc_ext;
  logic                rd_stb, wr_stb, busy, start_req, stat_rd, valid;
  logic                unused_bits;

  assign unused_bits = ^sdata_in;

  gpio_mulcore_popcount #(.IN_W(32)) u_popcount (
    .data_i (acc_ext[31:0]),
    .ones_o (ones_w)
  );

  always_comb begin
    rd_stb    = srd & ~srd_prev_q;
    wr_stb    = swr & ~swr_prev_q;
    busy      = (state_q != S_IDLE);
    valid     = (resh_q == 32'h0);
    start_req = wr_stb && (saddress == ADDR_CSR);
    stat_rd   = rd_stb && (saddress == ADDR_CSR);
    mac_sum   = {1'b0, acc_q} + {1'b0, prod_q};
    acc_d     = (mode_q == MODE_MUL) ? prod_q : mac_sum[ACC_W-1:0];
    acc_ext   = 64'(acc_q);
    // Clearing read and a same-cycle set: the set wins so no event is lost.
    err_d     = (err_q & ~stat_rd) | (start_req & busy);
    carry_d   = (carry_q & ~stat_rd) | ((state_q == S_FINISH) & carry_pend_q);
    rdata_d   = '0;
    case (saddress)
      ADDR_A1:   rdata_d = DATA_W'(a1_q);
      ADDR_A2:   rdata_d = DATA_W'(a2_q);
      ADDR_RESL: rdata_d = DATA_W'(resl_q);
      ADDR_RESH: rdata_d = DATA_W'(resh_q);
      ADDR_ONES: rdata_d = DATA_W'(ones_q);
      ADDR_CSR:  rdata_d = DATA_W'({carry_q, err_q, ~busy, valid});
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= S_IDLE;
      a1_q         <= '0;
      a2_q         <= '0;
      wa_q         <= '0;
      wb_q         <= '0;
      prod_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mode_q       <= MODE_MUL;
      carry_pend_q <= 1'b0;
      err_q        <= 1'b0;
      carry_q      <= 1'b0;
      resl_q       <= '0;
      resh_q       <= '0;
      ones_q       <= '0;
      op_count_q   <= '0;
      srd_prev_q   <= 1'b0;
      swr_prev_q   <= 1'b0;
      latch_prev_q <= 1'b0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
      insp_q       <= '0;
    end else begin
      srd_prev_q   <= srd;
      swr_prev_q   <= swr;
      latch_prev_q <= gpio_latch;
      err_q        <= err_d;
      carry_q      <= carry_d;
      irq_q        <= 1'b0;
      if (gpio_latch && !latch_prev_q) insp_q <= gpio_in;
      if (rd_stb) rdata_q <= rdata_d;
      if (wr_stb && (saddress == ADDR_A1)) a1_q <= sdata_in[OP_W-1:0];
      if (wr_stb && (saddress == ADDR_A2)) a2_q <= sdata_in[OP_W-1:0];

      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            wa_q    <= ACC_W'(a1_q);
            wb_q    <= a2_q;
            prod_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= sdata_in[CSR_MODE_BIT];
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (wb_q[0]) prod_q <= prod_q + wa_q;
          wa_q  <= wa_q << 1;
          wb_q  <= wb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(OP_W - 1)) state_q <= S_COUNT;
        end
        S_COUNT: begin
          acc_q        <= acc_d;
          carry_pend_q <= (mode_q == MODE_MAC) & mac_sum[ACC_W];
          state_q      <= S_FINISH;
        end
        S_FINISH: begin
          resl_q     <= acc_ext[31:0];
          resh_q     <= acc_ext[63:32];
          ones_q     <= ones_w;
          irq_q      <= 1'b1;
          op_count_q <= op_count_q + 16'd1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sdata_out      = rdata_q;
  assign gpio_in_s_insp = insp_q;
  assign gpio_out       = {16'h0, op_count_q};
  assign irq            = irq_q;

endmodule
